// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator channel responder
package calc_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    OVF     = 2'd2,
    INVALID = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int unsigned EXEC_CYCLES_MIN = 1;
  localparam int unsigned EXEC_CYCLES_MAX = 6;
  // Wide enough to hold EXEC_CYCLES_MAX-1
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/calc_port_responder_if.sv
// rtl/calc_port_responder_if.sv - calculator channel request/response pins
interface calc_port_responder_if;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        out_busy;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, out_busy
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, out_busy
  );
endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational add/sub/shift unit; CALC_SHIFT_EN enables cmd 5/6
module calc_alu
  import calc_pkg::*;
(
  input  cmd_t        cmd_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output resp_t       resp_o,
  output logic [31:0] data_o
);

  logic [32:0] sum;

  always_comb begin
    resp_o = INVALID;
    data_o = '0;
    sum    = {1'b0, op1_i} + {1'b0, op2_i};
    case (cmd_i)
      ADD: begin
        if (sum[32]) begin
          resp_o = OVF;
        end else begin
          resp_o = OK;
          data_o = sum[31:0];
        end
      end
      SUB: begin
        if (op2_i > op1_i) begin
          resp_o = OVF;
        end else begin
          resp_o = OK;
          data_o = op1_i - op2_i;
        end
      end
`ifdef CALC_SHIFT_EN
      SHL: begin
        resp_o = OK;
        data_o = op1_i << op2_i[4:0];
      end
      SHR: begin
        resp_o = OK;
        data_o = op1_i >> op2_i[4:0];
      end
`endif
      default: begin
        resp_o = INVALID;
        data_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc_port_responder.sv
// rtl/calc_port_responder.sv - single-channel calculator responder FSM
// EXEC_CYCLES must stay within EXEC_CYCLES_MIN..EXEC_CYCLES_MAX; shifts need CALC_SHIFT_EN.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 3
) (
  input logic                 c_clk,
  input logic                 reset,
  calc_port_responder_if.slave bus
);

  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  resp_t            resp_q, resp_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;

  resp_t            alu_resp;
  logic [31:0]      alu_data;

  calc_alu u_alu (
    .cmd_i  (cmd_t'(cmd_q)),
    .op1_i  (op1_q),
    .op2_i  (op2_q),
    .resp_o (alu_resp),
    .data_o (alu_data)
  );

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= NONE;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    data_d  = data_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.req_cmd_in != 4'd0) begin
          cmd_d   = bus.req_cmd_in;
          op1_d   = bus.req_data_in;
          busy_d  = 1'b1;
          state_d = OP2;
        end
      end
      OP2: begin
        op2_d   = bus.req_data_in;
        cnt_d   = CNT_W'(EXEC_CYCLES - 1);
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == '0) begin
          resp_d  = alu_resp;
          data_d  = (alu_resp == OK) ? alu_data : 32'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Response is one cycle wide; busy drops on the same edge
        resp_d  = NONE;
        data_d  = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_resp = resp_q;
  assign bus.out_data = data_q;
  assign bus.out_busy = busy_q;

endmodule
